comparator_seq: RTL

- Parametrised, multi-cycle successor to the team's combinational equality comparator.
- Compares two N-bit operands CHUNK bits per cycle, MSB chunk first.
- Produces registered eq/lt/gt flags in either signed or unsigned mode.
- Sits behind a valid/ready handshake so ALU/datapath stages can share one narrow compare slice for wide operands.

---
 rtl/comparator_pkg.sv | 25 ++
 rtl/comparator_seq_if.sv | 27 ++
 rtl/comparator_chunk.sv | 29 ++
 rtl/comparator_seq.sv | 140 ++++++++++++++
 4 files changed

// File: rtl/comparator_pkg.sv
// Shared types and sizing helpers for the sequential chunked comparator.
package comparator_pkg;

  typedef enum logic [1:0] {
    S_IDLE,
    S_SCAN,
    S_DONE
  } cmp_state_t;

  typedef struct packed {
    logic eq;
    logic lt;
    logic gt;
  } cmp_result_t;

  function automatic int unsigned chunk_count(input int unsigned n, input int unsigned chunk);
    return n / chunk;
  endfunction

  // Index register keeps at least one bit so CHUNK == N still elaborates cleanly.
  function automatic int unsigned idx_width(input int unsigned nchunk);
    return (nchunk > 1) ? $clog2(nchunk) : 1;
  endfunction

endpackage

// File: rtl/comparator_seq_if.sv
// Request/response bundle for comparator_seq; slave is the comparator, master the requester.
interface comparator_seq_if #(
  parameter int unsigned N = 32
);

  logic         i_valid;
  logic         i_ready;
  logic [N-1:0] a;
  logic [N-1:0] b;
  logic         signed_mode;
  logic         o_valid;
  logic         o_ready;
  logic         eq;
  logic         lt;
  logic         gt;

  modport master (
    output i_valid, a, b, signed_mode, o_ready,
    input  i_ready, o_valid, eq, lt, gt
  );

  modport slave (
    input  i_valid, a, b, signed_mode, o_ready,
    output i_ready, o_valid, eq, lt, gt
  );

endinterface

// File: rtl/comparator_chunk.sv
// Combinational compare of one CHUNK-bit slice; msb_invert turns the unsigned compare
// into a two's-complement one by flipping the sign bit of both operands.
module comparator_chunk #(
  parameter int unsigned CHUNK = 8
) (
  input  logic [CHUNK-1:0] a,
  input  logic [CHUNK-1:0] b,
  input  logic             msb_invert,
  output logic             chunk_eq,
  output logic             chunk_lt,
  output logic             chunk_gt
);

  logic [CHUNK-1:0] flip;
  logic [CHUNK-1:0] a_x;
  logic [CHUNK-1:0] b_x;

  always_comb begin
    flip          = '0;
    flip[CHUNK-1] = msb_invert;
    a_x           = a ^ flip;
    b_x           = b ^ flip;
  end

  assign chunk_eq = &(a ~^ b);
  assign chunk_lt = (a_x < b_x);
  assign chunk_gt = (a_x > b_x);

endmodule

// File: rtl/comparator_seq.sv
// Multi-cycle eq/lt/gt comparator scanning CHUNK bits per cycle, MSB chunk first.
// Define COMPARATOR_SEQ_EARLY_EXIT_EN to stop on the first differing chunk.
module comparator_seq
  import comparator_pkg::*;
#(
  parameter int unsigned N     = 32,
  parameter int unsigned CHUNK = 8
) (
  input logic             clk,
  input logic             rst,
  comparator_seq_if.slave bus
);

  localparam int unsigned NCHUNK = chunk_count(N, CHUNK);
  localparam int unsigned IdxW   = idx_width(NCHUNK);
  localparam logic [IdxW-1:0] IdxTop = IdxW'(NCHUNK - 1);

  if ((CHUNK < 1) || (CHUNK > N) || ((N % CHUNK) != 0)) begin : g_bad_params
    $error("comparator_seq: N must be a non-zero multiple of CHUNK");
  end

  cmp_state_t  state_q;
  logic [N-1:0] a_q;
  logic [N-1:0] b_q;
  logic         smode_q;
  logic [IdxW-1:0] idx_q;
  cmp_result_t res_q;
  logic        ready_q;
  logic        valid_q;

  logic [CHUNK-1:0] ca;
  logic [CHUNK-1:0] cb;
  logic             c_eq;
  logic             c_lt;
  logic             c_gt;
  logic             msb_invert;

  assign ca         = a_q[CHUNK*int'(idx_q) +: CHUNK];
  assign cb         = b_q[CHUNK*int'(idx_q) +: CHUNK];
  assign msb_invert = smode_q && (idx_q == IdxTop);

  comparator_chunk #(
    .CHUNK(CHUNK)
  ) u_chunk (
    .a         (ca),
    .b         (cb),
    .msb_invert(msb_invert),
    .chunk_eq  (c_eq),
    .chunk_lt  (c_lt),
    .chunk_gt  (c_gt)
  );

`ifndef COMPARATOR_SEQ_EARLY_EXIT_EN
  // Sticky verdict of the first differing chunk; later chunks must not override it.
  logic dec_q;
  logic dec_lt_q;
  logic dec_gt_q;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= S_IDLE;
      a_q      <= '0;
      b_q      <= '0;
      smode_q  <= 1'b0;
      idx_q    <= IdxTop;
      res_q    <= '0;
      ready_q  <= 1'b1;
      valid_q  <= 1'b0;
`ifndef COMPARATOR_SEQ_EARLY_EXIT_EN
      dec_q    <= 1'b0;
      dec_lt_q <= 1'b0;
      dec_gt_q <= 1'b0;
`endif
    end else begin
      case (state_q)
        S_IDLE: begin
          if (bus.i_valid && ready_q) begin
            a_q     <= bus.a;
            b_q     <= bus.b;
            smode_q <= bus.signed_mode;
            idx_q   <= IdxTop;
            ready_q <= 1'b0;
            state_q <= S_SCAN;
`ifndef COMPARATOR_SEQ_EARLY_EXIT_EN
            dec_q   <= 1'b0;
`endif
          end
        end

        S_SCAN: begin
`ifdef COMPARATOR_SEQ_EARLY_EXIT_EN
          if (!c_eq) begin
            res_q   <= '{eq: 1'b0, lt: c_lt, gt: c_gt};
            valid_q <= 1'b1;
            state_q <= S_DONE;
          end else if (idx_q == '0) begin
            res_q   <= '{eq: 1'b1, lt: 1'b0, gt: 1'b0};
            valid_q <= 1'b1;
            state_q <= S_DONE;
          end else begin
            idx_q <= idx_q - 1'b1;
          end
`else
          if (!c_eq && !dec_q) begin
            dec_q    <= 1'b1;
            dec_lt_q <= c_lt;
            dec_gt_q <= c_gt;
          end
          if (idx_q == '0) begin
            res_q   <= dec_q ? '{eq: 1'b0, lt: dec_lt_q, gt: dec_gt_q}
                             : '{eq: c_eq, lt: c_lt, gt: c_gt};
            valid_q <= 1'b1;
            state_q <= S_DONE;
          end else begin
            idx_q <= idx_q - 1'b1;
          end
`endif
        end

        S_DONE: begin
          if (bus.o_ready) begin
            valid_q <= 1'b0;
            ready_q <= 1'b1;
            state_q <= S_IDLE;
          end
        end

        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign bus.i_ready = ready_q;
  assign bus.o_valid = valid_q;
  assign bus.eq      = res_q.eq;
  assign bus.lt      = res_q.lt;
  assign bus.gt      = res_q.gt;

endmodule
